fu_issue: RTL and testbench

- Initiator side of the function-unit interface: accepts operation requests over a valid/ready handshake and drives operands and the function select to the combinational FU.
- Holds FU inputs stable for the operation's execution window, then captures f/z/n into a response FIFO returned over valid/ready.
- Treats FMUL as a multi-cycle path.
- Keeps a sticky-flag status and an operation counter.
- Sits between the control sequencer and the FU in the mycpu datapath.

---
 rtl/mycpu_pkg.sv | 46 ++++
 rtl/fu_rsp_fifo.sv | 64 ++++++
 rtl/fu_issue.sv | 152 +++++++++++++++
 tb/tb_fu_issue.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu datapath: function selects, FU width,
// response entry layout and the issue-stage state encoding.
package mycpu_pkg;

    localparam int FU_W       = 16;
    localparam int RSP_TAG_W  = 4;

    // Function select encodings understood by the combinational FU
    typedef enum logic [3:0] {
        FMOVA = 4'h0,
        FINC  = 4'h1,
        FADD  = 4'h2,
        FADDC = 4'h3,
        FSUBB = 4'h4,
        FSUB  = 4'h5,
        FDEC  = 4'h6,
        FMUL  = 4'h7,
        FAND  = 4'h8,
        FOR   = 4'h9,
        FXOR  = 4'hA,
        FNOT  = 4'hB,
        FMOVB = 4'hC,
        FSHR  = 4'hD,
        FSHL  = 4'hE,
        FCLR  = 4'hF
    } fs_t;

    // One captured FU result as it travels back to the sequencer
    typedef struct packed {
        logic [FU_W-1:0]      f;
        logic                 z;
        logic                 n;
        logic [RSP_TAG_W-1:0] tag;
    } rsp_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_t;

    // Only the multiplier is timed as a multi-cycle path through the FU
    function automatic logic is_multicycle(input fs_t fs);
        return (fs == FMUL);
    endfunction

endpackage

// File: rtl/fu_rsp_fifo.sv
// Small synchronous FIFO holding FU responses; the element type is a
// parameter so the issue stage can carry its own tag width.
module fu_rsp_fifo
    import mycpu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = rsp_entry_t,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees the slot
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < DEPTH_C) || do_pop);
    end

    // Storage, wrapping pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/fu_issue.sv
// Issue stage between the control sequencer and the combinational FU:
// latches a request onto the FU inputs, holds them for the execution
// window, then queues f/z/n with the request tag for the consumer.
module fu_issue
    import mycpu_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int RSP_DEPTH  = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_fs,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      a_out,
    output logic [15:0]      b_out,
    output logic [3:0]       fs_out,
    input  logic [15:0]      f_in,
    input  logic             z_in,
    input  logic             n_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_f,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             z_sticky,
    output logic             n_sticky,
    output logic [15:0]      op_count,
    input  logic             clr_status
);

    localparam int                CNT_W    = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0]  MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
    localparam int                FCNT_W   = $clog2(RSP_DEPTH + 1);
    localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(RSP_DEPTH);

    typedef struct packed {
        logic [FU_W-1:0]  f;
        logic             z;
        logic             n;
        logic [TAG_W-1:0] tag;
    } entry_t;

    issue_state_t      state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [TAG_W-1:0]  tag_q;
    logic              run_q;
    logic [FCNT_W-1:0] fifo_count;
    logic              accept;
    logic              push;
    logic              pop;
    entry_t            push_data;
    entry_t            head;

    // Readiness comes purely from flops so rsp_ready never ripples into req_ready
    assign req_ready = run_q && (state == IDLE) && (fifo_count < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign push      = (state == EXEC) && (cycle_cnt == ONE);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state == EXEC);

    assign push_data = '{f: f_in, z: z_in, n: n_in, tag: tag_q};

    // Holds req_ready low through reset and the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Issue FSM: capture on accept, count down the execution window, then hand back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            tag_q     <= '0;
            a_out     <= '0;
            b_out     <= '0;
            fs_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_out     <= req_a;
                        b_out     <= req_b;
                        fs_out    <= req_fs;
                        tag_q     <= req_tag;
                        cycle_cnt <= is_multicycle(fs_t'(req_fs)) ? MUL_LOAD : ONE;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    cycle_cnt <= cycle_cnt - 1'b1;
                    if (cycle_cnt == ONE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags and op counter; a clear that lands with a push keeps that push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_sticky <= 1'b0;
            n_sticky <= 1'b0;
            op_count <= '0;
        end else if (push && clr_status) begin
            z_sticky <= z_in;
            n_sticky <= n_in;
            op_count <= 16'd1;
        end else if (push) begin
            z_sticky <= z_sticky | z_in;
            n_sticky <= n_sticky | n_in;
            op_count <= op_count + 16'd1;
        end else if (clr_status) begin
            z_sticky <= 1'b0;
            n_sticky <= 1'b0;
            op_count <= '0;
        end
    end

    fu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (entry_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

    assign rsp_f   = head.f;
    assign rsp_z   = head.z;
    assign rsp_n   = head.n;
    assign rsp_tag = head.tag;

endmodule

// File: tb/tb_fu_issue.sv
// Directed bench for fu_issue with a behavioural FU hanging off a_out/b_out/fs_out.
module tb_fu_issue;
    import mycpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    fs_t         req_fs;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_tag;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [3:0]  fs_out;
    logic [15:0] f_in;
    logic        z_in;
    logic        n_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_f;
    logic        rsp_z;
    logic        rsp_n;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic        z_sticky;
    logic        n_sticky;
    logic [15:0] op_count;
    logic        clr_status;

    int tests_run = 0;
    int tests_failed = 0;

    fu_issue #(
        .MUL_CYCLES (3),
        .RSP_DEPTH  (2),
        .TAG_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fs     (req_fs),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .a_out      (a_out),
        .b_out      (b_out),
        .fs_out     (fs_out),
        .f_in       (f_in),
        .z_in       (z_in),
        .n_in       (n_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_f      (rsp_f),
        .rsp_z      (rsp_z),
        .rsp_n      (rsp_n),
        .rsp_tag    (rsp_tag),
        .busy       (busy),
        .z_sticky   (z_sticky),
        .n_sticky   (n_sticky),
        .op_count   (op_count),
        .clr_status (clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational FU
    always_comb begin
        f_in = 16'h0000;
        case (fs_t'(fs_out))
            FMOVA:   f_in = a_out;
            FINC:    f_in = a_out + 16'd1;
            FADD:    f_in = a_out + b_out;
            FADDC:   f_in = a_out + b_out + 16'd1;
            FSUBB:   f_in = a_out + ~b_out;
            FSUB:    f_in = a_out - b_out;
            FDEC:    f_in = a_out - 16'd1;
            FMUL:    f_in = a_out * b_out;
            FAND:    f_in = a_out & b_out;
            FOR:     f_in = a_out | b_out;
            FXOR:    f_in = a_out ^ b_out;
            FNOT:    f_in = ~a_out;
            FMOVB:   f_in = b_out;
            FSHR:    f_in = b_out >> 1;
            FSHL:    f_in = b_out << 1;
            default: f_in = 16'h0000;
        endcase
        z_in = (f_in == 16'h0000);
        n_in = f_in[15];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) for it to be accepted
    task automatic applyStimulus(input fs_t fs, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        logic accepted;
        accepted  = 1'b0;
        req_fs    = fs;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (req_ready) accepted = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        checkOutput("accept", {31'd0, accepted}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_fs     = FMOVA;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        req_tag    = 4'h0;
        rsp_ready  = 1'b1;
        clr_status = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_a_out", {16'd0, a_out}, 32'h0);
        checkOutput("rst_fs_out", {28'd0, fs_out}, 32'h0);
        checkOutput("rst_op_count", {16'd0, op_count}, 32'h0);
        checkOutput("rst_rsp_f", {16'd0, rsp_f}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // 1: FADD 0x7FFF + 0x0002 = 0x8001, negative
        applyStimulus(FADD, 16'h7FFF, 16'h0002, 4'h3);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        checkOutput("t1_a_out", {16'd0, a_out}, 32'h7FFF);
        checkOutput("t1_fs_out", {28'd0, fs_out}, 32'h2);
        checkOutput("t1_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("t1_rsp_f", {16'd0, rsp_f}, 32'h8001);
        checkOutput("t1_rsp_z", {31'd0, rsp_z}, 32'd0);
        checkOutput("t1_rsp_n", {31'd0, rsp_n}, 32'd1);
        checkOutput("t1_rsp_tag", {28'd0, rsp_tag}, 32'h3);
        checkOutput("t1_op_count", {16'd0, op_count}, 32'd1);
        checkOutput("t1_n_sticky", {31'd0, n_sticky}, 32'd1);
        checkOutput("t1_busy_done", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("t1_popped", {31'd0, rsp_valid}, 32'd0);

        // 2: FMUL 3 * 0x2AAB = 0x8001 (low 16 bits), held three cycles
        applyStimulus(FMUL, 16'h0003, 16'h2AAB, 4'h5);
        checkOutput("t2_busy_c1", {31'd0, busy}, 32'd1);
        checkOutput("t2_b_out_c1", {16'd0, b_out}, 32'h2AAB);
        tick();
        checkOutput("t2_busy_c2", {31'd0, busy}, 32'd1);
        checkOutput("t2_a_out_c2", {16'd0, a_out}, 32'h0003);
        checkOutput("t2_no_rsp_c2", {31'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("t2_busy_c3", {31'd0, busy}, 32'd1);
        checkOutput("t2_fs_out_c3", {28'd0, fs_out}, 32'h7);
        checkOutput("t2_b_out_c3", {16'd0, b_out}, 32'h2AAB);
        checkOutput("t2_no_rsp_c3", {31'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("t2_rsp_f", {16'd0, rsp_f}, 32'h8001);
        checkOutput("t2_rsp_tag", {28'd0, rsp_tag}, 32'h5);
        checkOutput("t2_busy_done", {31'd0, busy}, 32'd0);
        checkOutput("t2_a_out_held", {16'd0, a_out}, 32'h0003);
        tick();

        // 3: back-pressure with a two-entry FIFO
        rsp_ready = 1'b0;
        applyStimulus(FMOVA, 16'h0000, 16'h0000, 4'h0);
        applyStimulus(FMOVA, 16'h0001, 16'h0000, 4'h1);
        tick();
        checkOutput("t3_full_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("t3_head_f0", {16'd0, rsp_f}, 32'h0000);
        checkOutput("t3_head_z0", {31'd0, rsp_z}, 32'd1);
        checkOutput("t3_head_tag0", {28'd0, rsp_tag}, 32'h0);
        req_fs    = FMOVA;
        req_a     = 16'h0002;
        req_b     = 16'h0000;
        req_tag   = 4'h2;
        req_valid = 1'b1;
        tick();
        checkOutput("t3_blocked1", {31'd0, req_ready}, 32'd0);
        checkOutput("t3_head_hold", {16'd0, rsp_f}, 32'h0000);
        tick();
        checkOutput("t3_blocked2", {31'd0, req_ready}, 32'd0);
        checkOutput("t3_idle_blocked", {31'd0, busy}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("t3_head_f1", {16'd0, rsp_f}, 32'h0001);
        checkOutput("t3_head_z1", {31'd0, rsp_z}, 32'd0);
        checkOutput("t3_ready_after_pop", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("t3_third_busy", {31'd0, busy}, 32'd1);
        checkOutput("t3_third_a_out", {16'd0, a_out}, 32'h0002);
        tick();
        rsp_ready = 1'b1;
        checkOutput("t3_head_still_f1", {16'd0, rsp_f}, 32'h0001);
        tick();
        checkOutput("t3_head_f2", {16'd0, rsp_f}, 32'h0002);
        checkOutput("t3_head_tag2", {28'd0, rsp_tag}, 32'h2);
        tick();
        checkOutput("t3_drained", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t3_op_count", {16'd0, op_count}, 32'd5);
        checkOutput("t3_z_sticky", {31'd0, z_sticky}, 32'd1);

        // 4: sticky flags and counter with a clear on the push cycle
        applyStimulus(FINC, 16'hFFFF, 16'h0000, 4'h4);
        tick();
        checkOutput("t4_finc_f", {16'd0, rsp_f}, 32'h0000);
        checkOutput("t4_finc_z", {31'd0, rsp_z}, 32'd1);
        applyStimulus(FDEC, 16'h8000, 16'h0000, 4'h5);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checkOutput("t4_fdec_f", {16'd0, rsp_f}, 32'h7FFF);
        checkOutput("t4_clr_push_z", {31'd0, z_sticky}, 32'd0);
        checkOutput("t4_clr_push_n", {31'd0, n_sticky}, 32'd0);
        checkOutput("t4_clr_push_cnt", {16'd0, op_count}, 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checkOutput("t4_clr_only_cnt", {16'd0, op_count}, 32'd0);

        // 5: reset in the middle of an FMUL
        applyStimulus(FMUL, 16'h0003, 16'h0005, 4'h6);
        tick();
        checkOutput("t5_mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_rst_a_out", {16'd0, a_out}, 32'h0);
        checkOutput("t5_rst_b_out", {16'd0, b_out}, 32'h0);
        checkOutput("t5_rst_fs_out", {28'd0, fs_out}, 32'h0);
        checkOutput("t5_rst_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t5_rst_rsp_f", {16'd0, rsp_f}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t5_no_ghost_rsp", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t5_no_ghost_cnt", {16'd0, op_count}, 32'd0);
        applyStimulus(FAND, 16'hFFFF, 16'h00FF, 4'h7);
        tick();
        checkOutput("t5_fand_f", {16'd0, rsp_f}, 32'h00FF);
        checkOutput("t5_fand_tag", {28'd0, rsp_tag}, 32'h7);
        checkOutput("t5_fand_cnt", {16'd0, op_count}, 32'd1);
        tick();

        // 6: op_count wraps from 0xFFFF to 0x0000
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        applyStimulus(FCLR, 16'h1234, 16'h5678, 4'h8);
        tick();
        checkOutput("t6_wrap_cnt", {16'd0, op_count}, 32'h0000);
        checkOutput("t6_z_sticky", {31'd0, z_sticky}, 32'd1);
        checkOutput("t6_fclr_f", {16'd0, rsp_f}, 32'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
